// File: rtl/fsmc_wr_fifo.sv
// FSMC write window: push-only data port feeding a show-ahead FIFO that drains over a
// valid/ready stream, plus a STATUS register and a self-clearing CTRL register.
module fsmc_wr_fifo #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 18,
    parameter int unsigned DEPTH  = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 18'h100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bus_wr,
    input  logic              bus_rd,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              bus_rvalid,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [CW-1:0]     count;
    logic              ovf;

    logic [PW-1:0]     rd_ptr_d, wr_ptr_d;
    logic [CW-1:0]     count_d;
    logic              ovf_d;

    logic [ADDR_W-1:0] offset;
    logic              sel_data, sel_status, sel_ctrl;
    logic              full, empty;
    logic              push_req, push, pop, drop, flush, clr_ovf;
    logic [7:0]        count_ext;
    logic [DATA_W-1:0] status_word;

    // Address decode, FIFO handshakes and the STATUS image.
    always_comb begin
        offset     = bus_addr - BASE_ADDR;
        sel_data   = (offset == ADDR_W'(0));
        sel_status = (offset == ADDR_W'(1));
        sel_ctrl   = (offset == ADDR_W'(2));

        full    = (count == CW'(DEPTH));
        empty   = (count == '0);
        m_valid = !empty;
        m_data  = mem[rd_ptr];

        pop      = m_valid && m_ready;
        push_req = bus_wr && sel_data;
        flush    = bus_wr && sel_ctrl && bus_wdata[0];
        clr_ovf  = bus_wr && sel_ctrl && bus_wdata[1];
        // A pop in the same cycle frees the slot, so a full push is still accepted.
        push     = push_req && (!full || pop) && !flush;
        drop     = push_req && full && !pop && !flush;

        count_ext           = '0;
        count_ext[CW-1:0]   = count;
        status_word         = '0;
        status_word[15]     = ovf;
        status_word[14]     = full;
        status_word[13]     = empty;
        status_word[7:0]    = count_ext;
    end

    // Next-state for pointers, occupancy and the sticky overflow flag.
    always_comb begin
        rd_ptr_d = rd_ptr;
        wr_ptr_d = wr_ptr;
        count_d  = count;
        ovf_d    = ovf;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count_d = count + CW'(1);
            end else if (pop && !push) begin
                count_d = count - CW'(1);
            end
        end
        // A dropped word wins over a same-cycle clear.
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clr_ovf) begin
            ovf_d = 1'b0;
        end
    end

    // FIFO control state and read response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            ovf        <= 1'b0;
            bus_rvalid <= 1'b0;
            bus_rdata  <= '0;
        end else begin
            rd_ptr     <= rd_ptr_d;
            wr_ptr     <= wr_ptr_d;
            count      <= count_d;
            ovf        <= ovf_d;
            bus_rvalid <= bus_rd;
            if (bus_rd) begin
                bus_rdata <= sel_status ? status_word : '0;
            end
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus_wdata;
        end
    end

endmodule

// File: doc/fsmc_wr_fifo.md
Name: fsmc_wr_fifo

Overview:
- Downstream stage of the FSMC multiplexed-AD bus slave. It consumes the slave's decoded, single-cycle write and read strobes, already synchronous to clk.
- Implements a small memory-mapped window: a push-only data port, a status register and a control register.
- Data written by the MCU is buffered in a FIFO and handed to on-chip logic over a valid/ready stream.
- Gives the MCU a bulk-write path with flow-control visibility, in place of single-register writes.

Parameters:
- DATA_W, 16: bus and stream data width.
- ADDR_W, 18: bus address width; matches AD[17:0].
- DEPTH, 16: FIFO entries. Must be a power of 2, range 2..128.
- BASE_ADDR, 18'h100: window base address.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: asynchronous, active-high reset.
- bus_wr, in, 1: one-cycle write strobe from the bus slave.
- bus_rd, in, 1: one-cycle read strobe from the bus slave.
- bus_addr, in, ADDR_W: latched transaction address.
- bus_wdata, in, DATA_W: write data, valid with bus_wr.
- bus_rdata, out, DATA_W: read data returned to the bus slave.
- bus_rvalid, out, 1: one-cycle pulse; bus_rdata is valid.
- m_valid, out, 1: stream word available.
- m_data, out, DATA_W: stream word, the FIFO head.
- m_ready, in, 1: consumer accepts the word.

Behaviour:
- Reset: asynchronous, active-high.
  - Clears rd_ptr, wr_ptr, count, ovf and bus_rvalid; bus_rdata = 0.
  - m_valid = 0. m_data is don't-care while m_valid = 0.
  - Storage array is not cleared.
  - Assertion mid-transfer discards FIFO contents and any pending read response.
- Register map, offset = bus_addr - BASE_ADDR:
  - Offset 0, DATA, write-only: a write pushes bus_wdata.
  - Offset 1, STATUS, read-only: [15] ovf (sticky), [14] full, [13] empty, [12:8] = 0, [7:0] count zero-extended.
  - Offset 2, CTRL, write-only, self-clearing: bit0 flush, bit1 clear ovf.
  - Any other address: writes ignored; reads return 0.
  - Reads of DATA or CTRL return 0.
- Read timing:
  - bus_rd in cycle N drives bus_rdata and bus_rvalid=1 in cycle N+1.
  - The returned value is the register state at the start of cycle N, i.e. before cycle N's updates.
  - bus_rdata holds until the next read; bus_rvalid is high for exactly one cycle.
- Push: bus_wr to DATA with count<DEPTH writes mem[wr_ptr]; wr_ptr wraps modulo DEPTH; count+1.
- Full push: bus_wr to DATA with count==DEPTH and no same-cycle pop drops the word and sets ovf. Count and pointers are unchanged.
- Stream (show-ahead):
  - m_valid = (count != 0); m_data = mem[rd_ptr].
  - A push into an empty FIFO in cycle N gives m_valid=1 in cycle N+1.
  - Pop occurs when m_valid && m_ready: rd_ptr wraps modulo DEPTH; count-1.
  - m_ready while empty has no effect.
- Push and pop in the same cycle:
  - Both occur; count unchanged.
  - At full, the push is accepted (no ovf) because the pop frees the slot.
  - At empty, only the push occurs, since m_valid=0.
- Flush (CTRL bit0):
  - Pointers and count go to 0 in the next cycle; m_valid=0 in that cycle.
  - Overrides any same-cycle push or pop. A push in the flush cycle is discarded and does not set ovf.
  - ovf is untouched unless bit1 is also set.
- Clear ovf (CTRL bit1): ovf=0 next cycle. A full-push in the same cycle takes priority and leaves ovf=1.
- bus_wr and bus_rd asserted together: both are serviced independently.
- No combinational path from m_ready to any output.

Test Plan:
1. Reset released, then read STATUS → bus_rdata=16'h2000 and bus_rvalid high one cycle after bus_rd. m_valid=0.
2. m_ready=0; write 16'h0F0F, 16'h1234, 16'h00AA to 18'h100; read 18'h101 → 16'h0003. m_valid=1 with m_data=16'h0F0F one cycle after the first push. Then m_ready=1 → stream delivers 0F0F, 1234, 00AA on consecutive cycles; m_valid=0 afterwards.
3. m_ready=0; 17 pushes of 0..16 → STATUS=16'hC010. Set m_ready=1 → stream delivers 0..15 only. Write CTRL=16'h0002, then read STATUS → 16'h2000.
4. Fill to 16 entries; in one cycle push 16'hBEEF with m_ready=1 → count stays 16, ovf=0. Draining returns 1..15 then BEEF, confirming pointer wrap.
5. Push 5 words, then write CTRL=16'h0001 → STATUS reads 16'h2000 and m_valid=0 one cycle later. Push 16'h5555 → it is the next m_data.
6. Push 4 words, assert reset for 2 cycles mid-stream → m_valid=0 immediately, without waiting for clk. After release, STATUS=16'h2000. A read issued in the cycle before reset produces no bus_rvalid.
